// File: rtl/echo_scheduler.sv
// Stereo echo sequencer sharing one single-port delay RAM between both channels.
// Define ECHO_FEEDBACK_EN to write the wet mix back into the history (repeating echo).
module echo_scheduler #(
   parameter int DEPTH      = 1024,
   parameter int AW         = $clog2(DEPTH),
   parameter int GAIN_SHIFT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] delay_len,
   input  logic          bypass,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW:0]   ram_addr,
   output logic [15:0]   ram_wdata,
   input  logic [15:0]   ram_rdata
);

   typedef enum logic [2:0] {
      StClear, StIdle, StRdL, StRdR, StCap, StWrL, StWrR, StOut
   } state_t;

   localparam logic [AW+1:0] ClrWords = (AW + 2)'(2 * DEPTH);

   state_t        state_q, state_d;
   logic [AW+1:0] clr_cnt_q, clr_cnt_d;
   logic [AW-1:0] wr_ptr_q, delay_q, rd_ptr, dly_in;
   logic          bypass_q;
   logic [31:0]   samp_q;
   logic [15:0]   echo_l_q, echo_r_q;
   logic [15:0]   mix_l, mix_r, wdata_l, wdata_r;
   logic          accept, out_fire;

   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          ram_en_q, ram_en_d;
   logic          ram_we_q, ram_we_d;
   logic [AW:0]   ram_addr_q, ram_addr_d;
   logic [15:0]   ram_wdata_q, ram_wdata_d;

   function automatic logic [15:0] sat_mix(logic [15:0] s, logic [15:0] e);
      logic signed [15:0] e_sh;
      logic [16:0]        sum;
      e_sh = $signed(e) >>> GAIN_SHIFT;
      sum  = {s[15], s} + {e_sh[15], e_sh};
      if (sum[16] != sum[15]) begin
         return sum[16] ? 16'h8000 : 16'h7FFF;
      end
      return sum[15:0];
   endfunction

   // A zero delay would read the slot about to be overwritten; treat it as one sample.
   assign dly_in = (delay_len == '0) ? AW'(1) : delay_len;
   assign rd_ptr = wr_ptr_q - delay_q;
   assign mix_l  = sat_mix(samp_q[31:16], echo_l_q);
   assign mix_r  = sat_mix(samp_q[15:0], echo_r_q);

`ifdef ECHO_FEEDBACK_EN
   assign wdata_l = mix_l;
   assign wdata_r = mix_r;
`else
   assign wdata_l = samp_q[31:16];
   assign wdata_r = samp_q[15:0];
`endif

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      accept      = 1'b0;
      out_fire    = 1'b0;
      case (state_q)
         StClear: begin
            if (clr_cnt_q == ClrWords) begin
               state_d    = StIdle;
               in_ready_d = 1'b1;
               clr_cnt_d  = '0;
            end else begin
               ram_en_d   = 1'b1;
               ram_we_d   = 1'b1;
               ram_addr_d = clr_cnt_q[AW:0];
               clr_cnt_d  = clr_cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (in_valid && in_ready_q) begin
               accept     = 1'b1;
               state_d    = StRdL;
               ram_en_d   = 1'b1;
               ram_addr_d = {1'b0, wr_ptr_q - dly_in};
            end else begin
               in_ready_d = 1'b1;
            end
         end
         StRdL: begin
            state_d    = StRdR;
            ram_en_d   = 1'b1;
            ram_addr_d = {1'b1, rd_ptr};
         end
         StRdR: state_d = StCap;
         StCap: begin
            state_d     = StWrL;
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = {1'b0, wr_ptr_q};
            ram_wdata_d = wdata_l;
         end
         StWrL: begin
            state_d     = StWrR;
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = {1'b1, wr_ptr_q};
            ram_wdata_d = wdata_r;
         end
         StWrR: begin
            state_d     = StOut;
            out_valid_d = 1'b1;
            out_data_d  = bypass_q ? samp_q : {mix_l, mix_r};
         end
         StOut: begin
            if (out_ready) begin
               out_fire   = 1'b1;
               state_d    = StIdle;
               in_ready_d = 1'b1;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         delay_q     <= AW'(1);
         bypass_q    <= 1'b0;
         samp_q      <= '0;
         echo_l_q    <= '0;
         echo_r_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if (accept) begin
            samp_q   <= in_data;
            delay_q  <= dly_in;
            bypass_q <= bypass;
         end
         // Read data arrives the cycle after each read strobe.
         if (state_q == StRdR) echo_l_q <= ram_rdata;
         if (state_q == StCap) echo_r_q <= ram_rdata;
         if (out_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_echo_scheduler.sv
// Scoreboard bench for echo_scheduler: sample-indexed history model, RAM model, random traffic.
module tb_echo_scheduler;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int G     = 1;
`ifdef ECHO_FEEDBACK_EN
   localparam bit Fb = 1'b1;
`else
   localparam bit Fb = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] delay_len = '0;
   logic          bypass = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic          ram_en, ram_we;
   logic [AW:0]   ram_addr;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata = '0;
   logic [15:0]   mem [2*DEPTH];

   echo_scheduler #(.DEPTH(DEPTH), .AW(AW), .GAIN_SHIFT(G)) dut (
      .clk(clk), .rst(rst), .delay_len(delay_len), .bypass(bypass),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;
   int wl[$], wr[$], acc_cyc_q[$], acc_times[$];
   logic [31:0] expq[$], obs[$];
   int acc_cnt = 0, cur_n = 0, cur_d = 1;
   int or_mode = 0;  // 0 random, 1 always ready, 2 stalled
   bit clearing = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat16(int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 3))
         0: return 16'($urandom);
         1: return 16'h7000 | 16'($urandom_range(0, 4095));
         2: return 16'h8000 | 16'($urandom_range(0, 4095));
         default: return 16'($urandom_range(0, 255));
      endcase
   endfunction

   // Reference model: each accepted sample n hears the value written d samples earlier.
   initial begin : tracker
      forever begin
         @(negedge clk);
         if (!rst && in_valid && in_ready) begin
            int n, d, sl, sr, el, er, ml, mr;
            n  = wl.size();
            d  = (delay_len == 0) ? 1 : int'(delay_len);
            sl = int'($signed(in_data[31:16]));
            sr = int'($signed(in_data[15:0]));
            el = (n >= d) ? wl[n-d] : 0;
            er = (n >= d) ? wr[n-d] : 0;
            ml = sat16(sl + (el >>> G));
            mr = sat16(sr + (er >>> G));
            wl.push_back(Fb ? ml : sl);
            wr.push_back(Fb ? mr : sr);
            expq.push_back(bypass ? in_data : {16'(ml), 16'(mr)});
            acc_cyc_q.push_back(cyc);
            acc_times.push_back(cyc);
            cur_n = n;
            cur_d = d;
            acc_cnt++;
         end
      end
   end

   initial begin : monitor
      logic        prev_valid, prev_hs;
      logic [31:0] prev_data;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst || clearing) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (acc_cyc_q.size() > 0) check("latency", 64'(cyc - acc_cyc_q.pop_front()), 64'd6);
               else check("spurious_out_valid", 64'(out_valid), 64'd0);
            end
            if (prev_valid && !prev_hs && out_valid) check("out_stable", 64'(out_data), 64'(prev_data));
            if (out_valid) check("out_quiet", 64'({in_ready, ram_en}), 64'd0);
            if (ram_en && !out_valid) begin
               if (ram_we) check("wr_addr", 64'(ram_addr[AW-1:0]), 64'(cur_n % DEPTH));
               else check("rd_addr", 64'(ram_addr[AW-1:0]),
                          64'(((cur_n - cur_d) % DEPTH + DEPTH) % DEPTH));
            end
            if (out_valid && out_ready) begin
               if (expq.size() > 0) check("out_data", 64'(out_data), 64'(expq.pop_front()));
               else check("unexpected_out", 64'(out_valid), 64'd0);
               obs.push_back(out_data);
               prev_hs = 1'b1;
            end else begin
               prev_hs = 1'b0;
            end
            prev_valid = out_valid;
            prev_data  = out_data;
         end
      end
   end

   initial begin : ready_gen
      forever begin
         @(posedge clk);
         #1;
         out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   task automatic do_reset();
      clearing = 1'b1;
      in_valid = 1'b0;
      rst      = 1'b1;
      #3;
      check("reset_outputs", {7'd0, in_ready, out_valid, out_data, ram_en, ram_we, ram_addr,
                              ram_wdata}, 64'd0);
      expq.delete(); acc_cyc_q.delete(); wl.delete(); wr.delete(); obs.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         @(negedge clk);
         check("clear_write", 64'({in_ready, ram_en, ram_we, ram_addr, ram_wdata}),
               64'({3'b011, 5'(i), 16'h0000}));
      end
      @(negedge clk);
      check("clear_done", 64'({in_ready, ram_en}), 64'd2);
      clearing = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input int dly, input bit byp, input int gap);
      int target;
      in_data   = d;
      delay_len = AW'(dly);
      bypass    = byp;
      in_valid  = 1'b1;
      target    = acc_cnt + 1;
      for (int k = 0; k < 300 && acc_cnt < target; k++) begin
         @(posedge clk);
         #1;
      end
      if (acc_cnt < target) check("accept_timeout", 64'(acc_cnt), 64'(target));
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 1000 && expq.size() > 0; k++) @(negedge clk);
      check("drain", 64'(expq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      int base;
      #1;
      do_reset();

      // Impulse with delay 4.
      send(32'h1000_1000, 4, 1'b0, 0);
      for (int i = 0; i < 7; i++) send(32'h0, 4, 1'b0, 0);
      drain();
      check("impulse_dry", 64'(obs[0]), 64'h1000_1000);
      check("impulse_gap", 64'(obs[1]), 64'd0);
      check("impulse_echo", 64'(obs[4]), 64'h0800_0800);

      do_reset();
      send(32'h7000_7000, 1, 1'b0, 0);
      send(32'h7000_7000, 1, 1'b0, 0);
      drain();
      check("sat_pos", 64'(obs[1]), 64'h7FFF_7FFF);

      do_reset();
      send(32'h9000_9000, 1, 1'b0, 0);
      send(32'h9000_9000, 1, 1'b0, 0);
      drain();
      check("sat_neg", 64'(obs[1]), 64'h8000_8000);

      // Backpressure: stall in OUT for 20 cycles.
      or_mode = 2;
      send(32'h1234_ABCD, 2, 1'b0, 0);
      for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("bp_hold", 64'(out_valid), 64'd1);
      or_mode = 1;
      drain();

      // Back-to-back throughput.
      base = acc_times.size();
      for (int i = 0; i < 6; i++) send({rnd16(), rnd16()}, 5, 1'b0, 0);
      drain();
      for (int i = 0; i < 5; i++)
         check("period", 64'(acc_times[base+i+1] - acc_times[base+i]), 64'd7);

      // Pointer wrap-around with delay 3.
      do_reset();
      or_mode = 0;
      send(32'h1000_1000, 3, 1'b0, 0);
      for (int i = 1; i < 40; i++) send(32'h0, 3, 1'b0, $urandom_range(0, 1));
      drain();
      check("wrap_echo1", 64'(obs[3]), 64'h0800_0800);
      check("wrap_echo2", 64'(obs[6]), Fb ? 64'h0400_0400 : 64'd0);

      // Reset while writing the left channel.
      send(32'h5555_5555, 2, 1'b0, 0);
      for (int k = 0; k < 20 && !(ram_en && ram_we && !ram_addr[AW]); k++) @(negedge clk);
      check("found_wr_l", 64'({ram_en, ram_we, ram_addr[AW]}), 64'd6);
      do_reset();
      send(32'h1000_1000, 0, 1'b0, 0);
      send(32'h0, 0, 1'b0, 0);
      send(32'h0, 0, 1'b0, 0);
      drain();
      check("delay0_as_1", 64'(obs[1]), 64'h0800_0800);
      check("delay0_after", 64'(obs[2]), Fb ? 64'h0400_0400 : 64'd0);

      // Randomised traffic.
      for (int i = 0; i < 150; i++)
         send({rnd16(), rnd16()}, $urandom_range(0, DEPTH - 1), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 2));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/echo_scheduler.md
# echo_scheduler

Controller that sequences a single shared single-port delay RAM for both stereo echo channels. It accepts one 32-bit stereo sample per handshake, reads both channels' delayed samples, mixes them, writes the new history, and presents the processed sample downstream. It sits between the I2S receive path and the transmit path, replacing per-channel private delay arrays with one arbitrated RAM and a runtime-configurable delay.

## Interface
Parameters:
- DEPTH, 1024: delay-line length per channel in samples; power of two, ≥4.
- AW, $clog2(DEPTH): per-channel address width.
- GAIN_SHIFT, 1: echo attenuation; echo contributes `echo >>> GAIN_SHIFT`.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- delay_len  in  AW  echo delay in samples; sampled on accept.
- bypass  in  1  pass-through select; sampled on accept.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  {left[31:16], right[15:0]}, signed 16-bit each.
- out_valid  out  1  processed sample valid.
- out_ready  in  1  downstream accepts sample.
- out_data  out  32  {left, right} processed.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  write enable (valid with ram_en).
- ram_addr  out  AW+1  MSB 0 = left region, 1 = right region.
- ram_wdata  out  16  write data.
- ram_rdata  in  16  read data, 1-cycle latency after ram_en & !ram_we.

## Operation
- FSM states: CLEAR, IDLE, RD_L, RD_R, CAP, WR_L, WR_R, OUT.
- CLEAR: after reset, writes 0 to all 2·DEPTH addresses, one per cycle, in ascending order; in_ready=0 throughout; then IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, latch in_data, clamped delay (0→1, values ≥DEPTH impossible by width), and bypass; go RD_L.
- rd_ptr = (wr_ptr − delay) mod DEPTH, using AW-bit wrap-around.
- RD_L: read {0,rd_ptr}. RD_R: read {1,rd_ptr}; capture echo_l from ram_rdata. CAP: capture echo_r; no RAM access.
- Mix per channel: 17-bit sum = sample + (echo >>> GAIN_SHIFT); saturate to 16'h7FFF / 16'h8000.
- WR_L: write {0,wr_ptr}. WR_R: write {1,wr_ptr}. Write data is per Configuration.
- OUT: out_valid=1; out_data = bypass ? latched input : saturated mix. Held stable until out_ready. On out_valid & out_ready: wr_ptr ← wr_ptr+1 (wraps DEPTH−1→0), go IDLE.
- in_ready is 1 only in IDLE; no input is accepted while an output is pending.
- bypass does not alter the RAM sequence; history is always updated.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; wr_ptr=0; state CLEAR.
- CLEAR lasts exactly 2·DEPTH cycles; in_ready rises on the following cycle.
- Accept edge E0 → RD_L(E0+1), RD_R(+2), CAP(+3), WR_L(+4), WR_R(+5), out_valid high after edge E0+6.
- Minimum sample period with out_ready held high: 7 cycles.
- RAM outputs are registered; exactly one access per cycle; never two strobes in one cycle.
- rst asserted in any state, including mid-write: all outputs return to reset values immediately; CLEAR restarts from address 0.
- out_ready asserted outside OUT: ignored.

## Configuration
- ECHO_FEEDBACK_EN defined: RAM write data = saturated mix (feedback echo, repeats decaying by GAIN_SHIFT per pass).
- Not defined: RAM write data = dry input sample (single echo only).
- Output mix equation is identical in both builds.

## Test plan
- Reset then idle: in_ready stays 0 for 2·DEPTH cycles, RAM sees 2·DEPTH zero writes at addresses 0..2·DEPTH−1, then in_ready=1.
- DEPTH=16, delay_len=4, GAIN_SHIFT=1, no feedback: impulse 0x1000 both channels then zeros → outputs 0x1000, then 0x0800 on sample 4, zeros elsewhere.
- Saturation: history holds 0x7000, input 0x7000, GAIN_SHIFT=0 → out 0x7FFF; negative case 0x9000+0x9000 → 0x8000.
- Backpressure: hold out_ready=0 for 20 cycles in OUT → out_data stable, in_ready=0, no RAM access, wr_ptr unchanged.
- Wrap-around: DEPTH=16, delay_len=3, run 40 samples → write addresses cycle 0..15, reads at wr_ptr−3 mod 16; ECHO_FEEDBACK_EN build shows 0x1000, 0x0800, 0x0400 repeats.
- Reset asserted during WR_L → next cycle ram_en=0, out_valid=0, state CLEAR at address 0; delay_len=0 afterward behaves as 1.
